// File: rtl/serial_add_ctrl_if.sv
// Handshake and serial-bit bundle between the serial adder controller,
// its upstream shift registers and the issuing master.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             carry_in_i;
  logic             a_bit_i;
  logic             b_bit_i;
  logic             load_o;
  logic             shift_en_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;

  modport master (
    output start_i, carry_in_i,
    output a_bit_i, b_bit_i,
    input  load_o, shift_en_o,
    input  busy_o, done_o,
    input  sum_o, carry_o
  );

  modport slave (
    input  start_i, carry_in_i,
    input  a_bit_i, b_bit_i,
    output load_o, shift_en_o,
    output busy_o, done_o,
    output sum_o, carry_o
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Sequencer plus bit-serial adder: drives upstream LSB-first shifters,
// adds their bits with a registered carry and deserialises the sum.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic             bit_vld;
  logic             c_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic             accept;
  logic             last_bit;
  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] acc_nxt;

  assign accept   = bus.start_i &&
                    (state == IDLE || state == DONE);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign s_bit   = bus.a_bit_i ^ bus.b_bit_i ^ c_q;
  assign c_nxt   = (bus.a_bit_i & bus.b_bit_i) |
                   (bus.a_bit_i & c_q) |
                   (bus.b_bit_i & c_q);
  assign acc_nxt = {s_bit, acc[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):  if (accept) state_nxt = LOAD;
      (state == LOAD):  state_nxt = SHIFT;
      (state == SHIFT): if (last_bit) state_nxt = FLUSH;
      (state == FLUSH): state_nxt = DONE;
      (state == DONE):  state_nxt = accept ? LOAD : IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_vld <= bus.shift_en_o;
      if (accept)
        cnt <= '0;
      else if (state == SHIFT)
        cnt <= cnt + CW'(1);
    end
  end

  // FLUSH edge consumes the last bit, so publish the post-add values
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= 1'b0;
      acc     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept)
        c_q <= bus.carry_in_i;
      else if (bit_vld)
        c_q <= c_nxt;
      if (bit_vld)
        acc <= acc_nxt;
      if (state == FLUSH) begin
        sum_q   <= acc_nxt;
        carry_q <= c_nxt;
      end
    end
  end

  assign bus.load_o     = (state == LOAD);
  assign bus.shift_en_o = (state == SHIFT);
  assign bus.busy_o     = (state == LOAD) ||
                          (state == SHIFT) ||
                          (state == FLUSH);
  assign bus.done_o     = (state == DONE);
  assign bus.sum_o      = sum_q;
  assign bus.carry_o    = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with behavioural upstream shift registers
// and a queue of expected {carry,sum} results.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [W-1:0] a_val, b_val;
  logic [W-1:0] sra, srb;
  logic         qa, qb;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sra <= '0; srb <= '0;
      qa  <= 1'b0; qb <= 1'b0;
    end else if (bus.load_o) begin
      sra <= a_val; srb <= b_val;
    end else if (bus.shift_en_o) begin
      qa  <= sra[0]; qb <= srb[0];
      sra <= sra >> 1; srb <= srb >> 1;
    end
  end

  assign bus.a_bit_i = qa;
  assign bus.b_bit_i = qb;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [W:0] expq[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse pops one expected result
  always @(negedge clk_i) begin
    if (rst_n && bus.done_o) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_with_done", {31'd0, bus.busy_o}, 32'd0);
      if (expq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = expq.pop_front();
        chk("sum", {24'd0, bus.sum_o}, {24'd0, e[W-1:0]});
        chk("carry", {31'd0, bus.carry_o}, {31'd0, e[W]});
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic c);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    expq.push_back(r);
  endtask

  task automatic run_add(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic c,
                         output int lat,
                         output int nload,
                         output int nshift);
    bit seen;
    @(negedge clk_i);
    a_val = a; b_val = b;
    bus.carry_in_i = c;
    bus.start_i = 1'b1;
    push_exp(a, b, c);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.start_i = 1'b0;
    lat = 0; nload = 0; nshift = 0; seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      if (k > 1) @(negedge clk_i);
      nload  += int'(bus.load_o);
      nshift += int'(bus.shift_en_o);
      if (bus.done_o) begin
        lat = k - 1;
        seen = 1;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int lat, nl, ns, d1, n0;
  logic [W-1:0] ra, rb;
  logic rc;

  initial begin
    bus.start_i = 1'b0;
    bus.carry_in_i = 1'b0;
    a_val = '0; b_val = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_load", {31'd0, bus.load_o}, 32'd0);
    chk("rst_shift", {31'd0, bus.shift_en_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_sum", {24'd0, bus.sum_o}, 32'd0);
    chk("rst_carry", {31'd0, bus.carry_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);

    run_add(8'h3C, 8'h05, 1'b0, lat, nl, ns);
    chk("latency", lat, 10);
    chk("load_cycles", nl, 1);
    chk("shift_cycles", ns, 8);

    run_add(8'hFF, 8'h01, 1'b0, lat, nl, ns);
    run_add(8'hFF, 8'hFF, 1'b1, lat, nl, ns);

    // back-to-back with start held high
    @(negedge clk_i);
    a_val = 8'h12; b_val = 8'h34;
    bus.carry_in_i = 1'b0;
    bus.start_i = 1'b1;
    push_exp(8'h12, 8'h34, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    a_val = 8'hA0; b_val = 8'h0B;
    push_exp(8'hA0, 8'h0B, 1'b0);
    for (int k = 0; k < 20 && !bus.done_o; k++)
      @(negedge clk_i);
    chk("b2b_done1", {31'd0, bus.done_o}, 32'd1);
    d1 = cyc;
    @(negedge clk_i);
    chk("b2b_reload", {31'd0, bus.load_o}, 32'd1);
    bus.start_i = 1'b0;
    for (int k = 0; k < 20 && !bus.done_o; k++)
      @(negedge clk_i);
    chk("b2b_done2", {31'd0, bus.done_o}, 32'd1);
    chk("b2b_gap", cyc - d1, 11);
    repeat (2) @(negedge clk_i);

    // spurious start during SHIFT
    n0 = done_cnt;
    @(negedge clk_i);
    a_val = 8'h5A; b_val = 8'h21;
    bus.carry_in_i = 1'b1;
    bus.start_i = 1'b1;
    push_exp(8'h5A, 8'h21, 1'b1);
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.carry_in_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("mid_shift", {31'd0, bus.shift_en_o}, 32'd1);
    a_val = 8'h00; b_val = 8'h00;
    bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (25) @(negedge clk_i);
    chk("one_done", done_cnt - n0, 1);
    chk("sum_hold", {24'd0, bus.sum_o}, 32'h7C);

    // async reset mid-SHIFT
    @(negedge clk_i);
    a_val = 8'h77; b_val = 8'h66;
    bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_shift", {31'd0, bus.shift_en_o}, 32'd0);
    chk("ar_load", {31'd0, bus.load_o}, 32'd0);
    chk("ar_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("ar_sum", {24'd0, bus.sum_o}, 32'd0);
    chk("ar_carry", {31'd0, bus.carry_o}, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("ar_idle", {30'd0, bus.busy_o, bus.done_o}, 32'd0);
    run_add(8'h01, 8'h01, 1'b0, lat, nl, ns);
    chk("ar_latency", lat, 10);

    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_add(ra, rb, rc, lat, nl, ns);
    end

    repeat (3) @(negedge clk_i);
    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
